// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 acts as word)
//   - responder FSM state enum
//   - default base address of the MIPS data segment (DMEM_BASE)
//   - lane_be(): byte-enable pattern for a given size and low address bits
// Configuration macro referenced by users of this package: DMEM_FAULT_CHECK_EN.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [1:0]  SZ_BYTE   = 2'b00;
    localparam logic [1:0]  SZ_HALF   = 2'b01;
    localparam logic [1:0]  SZ_WORD   = 2'b10;

    localparam logic [31:0] DMEM_BASE = 32'h10010000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Byte enables for a store. Half accesses look only at addr[1], word
    // accesses at neither, so misaligned requests collapse onto their lane.
    function automatic logic [3:0] lane_be(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous RAM, 32-bit words, 4 byte write enables.
// One read or write per enabled cycle; rdata is registered and reflects the
// word after the write (read-during-write returns new data). Contents are
// never reset.
// Ports:
//   clk    in   rising-edge clock
//   en     in   perform an access this edge
//   be     in   [3:0] byte write enables (0 = pure read)
//   addr   in   [ADDR_W-1:0] word index
//   wdata  in   [31:0] write data, already placed in its lanes
//   rdata  out  [31:0] registered read data, updated only when en=1
// -----------------------------------------------------------------------------
module dmem_ram #(
    parameter int DEPTH_WORDS = 2048,
    parameter int ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] merged;

    // Old word with the enabled lanes overlaid: this is what rdata must show
    // on a write, so the read port sees the new data.
    always_comb begin
        merged = mem[addr];
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            rdata <= merged;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// CPU data-port responder: accepts one load/store over a valid/ready request
// channel, waits RD_LATENCY extra cycles, performs the byte/half/word access
// on dmem_ram, then presents the result on a valid/ready response channel.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1; the sender holds its payload stable until then, and valid never
// depends on ready. req_ready is a function of state (and rst) only.
//
// Optional feature macro: DMEM_FAULT_CHECK_EN
//   defined   - out-of-range or misaligned accesses raise rsp_err, suppress the
//               store and return rdata 0.
//   undefined - rsp_err is 0, the word index wraps, misaligned low address
//               bits are ignored.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   req_valid/req_ready   request handshake
//   req_we                1 store, 0 load
//   req_size              00 byte, 01 half, 10/11 word
//   req_sign              load sign-extend enable
//   req_addr [31:0]       CPU byte address
//   req_wdata [31:0]      right-aligned store data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata [31:0]      extended load data (0 for stores / faults)
//   rsp_err               access fault
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          RD_LATENCY  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    state_t      state, state_next;
    logic [2:0]  cnt;

    // Request captured at accept; held for the whole transaction.
    logic        q_we;
    logic [1:0]  q_size;
    logic        q_sign;
    logic [31:0] q_addr;
    logic [31:0] q_wdata;

    logic          access_fire;
    logic          fault;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlanes;
    logic [31:0]   ram_rdata;
    logic [7:0]    lane8;
    logic [15:0]   lane16;
    logic [31:0]   ext;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        q_we    <= req_we;
                        q_size  <= req_size;
                        q_sign  <= req_sign;
                        q_addr  <= req_addr;
                        q_wdata <= req_wdata;
                        cnt     <= '0;
                    end
                end
                ST_ACCESS: cnt <= cnt + 3'd1;
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                // Held low during reset so nothing is offered before the
                // FSM is known to be idle.
                req_ready = !rst;
                if (req_valid) state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (cnt == LAT) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------ address / fault
    // Base subtraction is 32-bit; only the word-index bits survive.
    assign idx = AW'((q_addr - BASE_ADDR) >> 2);

`ifdef DMEM_FAULT_CHECK_EN
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    logic out_of_range;
    logic misaligned;
    // Compared at 33 bits so a segment ending at 4 GiB cannot wrap.
    assign out_of_range = ({1'b0, q_addr} < {1'b0, BASE_ADDR}) ||
                          ({1'b0, q_addr} >= LIMIT);
    assign misaligned   = ((q_size == SZ_HALF) && q_addr[0]) ||
                          (q_size[1] && (q_addr[1:0] != 2'b00));
    assign fault        = out_of_range || misaligned;
`else
    assign fault = 1'b0;
`endif

    // ---------------------------------------------------------- RAM access
    assign access_fire = (state == ST_ACCESS) && (cnt == LAT);
    assign be          = lane_be(q_size, q_addr[1:0]);

    always_comb begin
        case (q_size)
            SZ_BYTE: wlanes = {4{q_wdata[7:0]}};
            SZ_HALF: wlanes = {2{q_wdata[15:0]}};
            default: wlanes = q_wdata;
        endcase
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_ram (
        .clk   (clk),
        .en    (access_fire && !rst),
        .be    ((q_we && !fault) ? be : 4'b0000),
        .addr  (idx),
        .wdata (wlanes),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------ response path
    // ram_rdata only changes on an access edge, so the extracted value is
    // stable for as long as the FSM sits in RESP.
    always_comb begin
        lane8  = ram_rdata[{q_addr[1:0], 3'b000} +: 8];
        lane16 = q_addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (q_size)
            SZ_BYTE: ext = {{24{q_sign & lane8[7]}}, lane8};
            SZ_HALF: ext = {{16{q_sign & lane16[15]}}, lane16};
            default: ext = ram_rdata;
        endcase
        rsp_rdata = '0;
        if ((state == ST_RESP) && !q_we && !fault) rsp_rdata = ext;
    end

    assign rsp_err = (state == ST_RESP) && fault;

endmodule
